// File: rtl/key_probe_sequencer.sv
// Serial key-device prober: walks N_BITS address nibbles, pulses SSER low per probe
// and assembles the SDRD samples into a word, LSB first.
module key_probe_sequencer #(
    parameter int N_BITS        = 8,
    parameter int STROBE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [4*N_BITS-1:0]   seq,
    input  logic                  SDRD,
    output logic                  SSER,
    output logic                  BA13,
    output logic                  BA12,
    output logic [3:0]            BA7_4,
    output logic                  BR_W,
    output logic [N_BITS-1:0]     data,
    output logic                  valid,
    output logic                  busy
);

    localparam int IW  = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int SCW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [IW-1:0]  LAST_IDX    = IW'(N_BITS - 1);
    localparam logic [SCW-1:0] LAST_STROBE = SCW'(STROBE_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [SCW-1:0]        cnt_q, cnt_d;
    logic [4*N_BITS-1:0]   seq_q, seq_d;
    logic [N_BITS-1:0]     data_q, data_d;
    logic                  sample;

    // Bus outputs are registered from the next state so SSER never glitches.
    logic                  sser_q, sser_d;
    logic                  ba13_q, ba13_d;
    logic                  ba12_q, ba12_d;
    logic [3:0]            nib_q, nib_d;
    logic                  addr_active_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        seq_d   = seq_q;
        data_d  = data_q;
        sample  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_SETUP;
                    seq_d   = seq;
                    idx_d   = '0;
                    data_d  = '0;
                end
            end
            S_SETUP: begin
                state_d = S_STROBE;
                cnt_d   = '0;
            end
            S_STROBE: begin
                if (cnt_q == LAST_STROBE) begin
                    state_d = S_HOLD;
                    sample  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (idx_q < LAST_IDX) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_SETUP;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort wins over the sample edge: the bit under strobe is discarded.
        if (abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            sample  = 1'b0;
        end

        if (sample) begin
            for (int i = 0; i < N_BITS; i++) begin
                if (IW'(i) == idx_q) data_d[i] = SDRD;
            end
        end
    end

    // DONE parks the address at the deselect pattern, same as IDLE.
    always_comb begin
        addr_active_d = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
        sser_d        = (state_d != S_STROBE);
        ba13_d        = !addr_active_d;
        ba12_d        = addr_active_d;
        nib_d         = addr_active_d ? 4'(seq_d >> {idx_d, 2'b00}) : 4'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            seq_q   <= '0;
            data_q  <= '0;
            sser_q  <= 1'b1;
            ba13_q  <= 1'b1;
            ba12_q  <= 1'b0;
            nib_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
            data_q  <= data_d;
            sser_q  <= sser_d;
            ba13_q  <= ba13_d;
            ba12_q  <= ba12_d;
            nib_q   <= nib_d;
        end
    end

    assign SSER  = sser_q;
    assign BA13  = ba13_q;
    assign BA12  = ba12_q;
    assign BA7_4 = nib_q;
    assign BR_W  = 1'b1;
    assign data  = data_q;
    assign valid = (state_q == S_DONE);
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_key_probe_sequencer.sv
// Bench for key_probe_sequencer: a cycle-count model of a transaction is checked every
// cycle, plus directed cases with hand-computed expectations.
module tb_key_probe_sequencer;

    localparam int NB = 8;
    localparam int SC = 2;
    localparam int PL = SC + 2;
    localparam int T  = NB * PL + 1;

    logic clk = 1'b0;
    logic rst;
    logic start, abort, SDRD;
    logic [4*NB-1:0] seq;
    logic SSER, BA13, BA12, BR_W, valid, busy;
    logic [3:0] BA7_4;
    logic [NB-1:0] data;

    logic start2, abort2, SDRD2;
    logic [3:0] seq2;
    logic SSER2, BA13_2, BA12_2, BR_W2, valid2, busy2;
    logic [3:0] BA7_4_2;
    logic [0:0] data2;

    int vectors = 0;
    int errors  = 0;
    logic checking = 1'b0;

    always #5 clk = ~clk;

    key_probe_sequencer #(.N_BITS(NB), .STROBE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .seq(seq), .SDRD(SDRD),
        .SSER(SSER), .BA13(BA13), .BA12(BA12), .BA7_4(BA7_4), .BR_W(BR_W),
        .data(data), .valid(valid), .busy(busy)
    );

    key_probe_sequencer #(.N_BITS(1), .STROBE_CYCLES(1)) dut_small (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .seq(seq2), .SDRD(SDRD2),
        .SSER(SSER2), .BA13(BA13_2), .BA12(BA12_2), .BA7_4(BA7_4_2), .BR_W(BR_W2),
        .data(data2), .valid(valid2), .busy(busy2)
    );

    // Model: a transaction is cycle k = 1..T after the accepting edge.
    logic          m_active = 1'b0;
    int            m_k      = 0;
    logic [31:0]   m_seq    = '0;
    logic [NB-1:0] m_data   = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_data   <= '0;
        end else if (!m_active) begin
            if (start && !abort) begin
                m_active <= 1'b1;
                m_k      <= 1;
                m_seq    <= seq;
                m_data   <= '0;
            end
        end else if (abort) begin
            m_active <= 1'b0;
        end else begin
            if (m_k < T && (m_k - 1) % PL == SC) m_data[(m_k - 1) / PL] <= SDRD;
            if (m_k == T) m_active <= 1'b0;
            else          m_k <= m_k + 1;
        end
    end

    logic [17:0] exp_out, act_out;
    always_comb begin
        int r;
        int p;
        r = 0;
        p = 0;
        exp_out = {1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, m_data};
        if (m_active) begin
            if (m_k == T) begin
                exp_out = {1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, m_data};
            end else begin
                r = (m_k - 1) % PL;
                p = (m_k - 1) / PL;
                exp_out = {!(r >= 1 && r <= SC), 1'b0, 1'b1, 1'b1, m_seq[4*p +: 4],
                           1'b0, 1'b1, m_data};
            end
        end
        act_out = {SSER, BA13, BA12, BR_W, BA7_4, valid, busy, data};
    end

    always @(negedge clk) begin
        if (checking) begin
            vectors++;
            if (act_out !== exp_out) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t actual=%b required=%b", $time, act_out, exp_out);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Drives one transaction from an IDLE negedge and observes it for T+2 cycles.
    task automatic run_txn(input logic [31:0] s, input logic [7:0] pat, input int abort_c,
                           input int restart_c, output int vcyc, output int nvalid,
                           output int nlow, output int npulse, output logic [31:0] nibs);
        logic prev_sser;
        int idx;
        vcyc = 0; nvalid = 0; nlow = 0; npulse = 0; nibs = '0; prev_sser = 1'b1;
        @(negedge clk);
        seq = s; start = 1'b1; abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= T + 2; c++) begin
            idx = (c - 1) / PL;
            if (idx > NB - 1) idx = NB - 1;
            SDRD  = pat[idx];
            abort = (c == abort_c);
            start = (c == restart_c);
            if (c == restart_c) seq = '0;
            if (valid) begin nvalid++; vcyc = c; end
            if (!SSER) nlow++;
            if (!SSER && prev_sser) npulse++;
            prev_sser = SSER;
            if (c < T && (c - 1) % PL == 0) nibs[4*idx +: 4] = BA7_4;
            @(negedge clk);
        end
        start = 1'b0; abort = 1'b0;
        $display("txn seq=%h pat=%b data=%h valids=%0d pulses=%0d", s, pat, data, nvalid, npulse);
    endtask

    logic [6:0] small_tab [5];
    int vcyc, nvalid, nlow, npulse;
    logic [31:0] nibs;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; SDRD = 1'b0; seq = '0;
        start2 = 1'b0; abort2 = 1'b0; SDRD2 = 1'b0; seq2 = 4'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checking = 1'b1;
        check("reset_outputs", {14'd0, act_out}, {14'd0, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 8'h00});

        // Reference transaction: pattern 1,0,1,1,0,0,1,0 first bit first.
        run_txn(32'h76543210, 8'b0100_1101, 0, 0, vcyc, nvalid, nlow, npulse, nibs);
        check("ref_valid_cycle", vcyc, 33);
        check("ref_valid_count", nvalid, 1);
        check("ref_sser_low_clks", nlow, 16);
        check("ref_sser_pulses", npulse, 8);
        check("ref_nibbles", nibs, 32'h76543210);
        check("ref_data", {24'd0, data}, 32'h4D);
        check("ref_busy_after", {31'd0, busy}, 0);

        // Abort in the 3rd probe's first strobe clock.
        run_txn(32'h76543210, 8'hFF, 10, 0, vcyc, nvalid, nlow, npulse, nibs);
        check("abort_valid_count", nvalid, 0);
        check("abort_data", {24'd0, data}, 32'h03);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_pulses", npulse, 3);

        // Start re-pulsed while busy with a zero seq.
        run_txn(32'h76543210, 8'hFF, 0, 5, vcyc, nvalid, nlow, npulse, nibs);
        check("restart_nibbles", nibs, 32'h76543210);
        check("restart_valid_count", nvalid, 1);
        check("restart_data", {24'd0, data}, 32'hFF);

        // Asynchronous reset in the middle of a strobe.
        @(negedge clk); seq = 32'h1234_5678; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("pre_rst_sser", {31'd0, SSER}, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_async_sser", {31'd0, SSER}, 1);
        check("rst_async_data", {24'd0, data}, 0);
        check("rst_async_busy", {31'd0, busy}, 0);
        @(negedge clk); rst = 1'b0;
        run_txn(32'hFFFF_FFFF, 8'hFF, 0, 0, vcyc, nvalid, nlow, npulse, nibs);
        check("post_rst_data", {24'd0, data}, 32'hFF);

        // Single-bit, single-strobe instance: SETUP, STROBE, HOLD, DONE then IDLE.
        small_tab[0] = 7'b1_1010_0_1;
        small_tab[1] = 7'b0_1010_0_1;
        small_tab[2] = 7'b1_1010_0_1;
        small_tab[3] = 7'b1_0000_1_1;
        small_tab[4] = 7'b1_0000_0_0;
        @(negedge clk); seq2 = 4'hA; start2 = 1'b1; SDRD2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("small_cycle%0d", c + 1), {25'd0, SSER2, BA7_4_2, valid2, busy2},
                  {25'd0, small_tab[c]});
            @(negedge clk);
        end
        check("small_data", {31'd0, data2}, 1);
        $display("txn small seq=a data=%b", data2);
        SDRD2 = 1'b0; start2 = 1'b1; abort2 = 1'b1;
        @(negedge clk); start2 = 1'b0; abort2 = 1'b0;
        check("small_start_abort_busy", {31'd0, busy2}, 0);
        @(negedge clk);
        check("small_start_abort_idle", {31'd0, busy2}, 0);
        check("small_data_held", {31'd0, data2}, 1);

        // Randomised transactions against the model.
        for (int t = 0; t < 40; t++) begin
            int c;
            repeat ($urandom_range(0, 3)) begin
                abort = ($urandom_range(0, 3) == 0);
                SDRD  = 1'($urandom);
                @(negedge clk);
            end
            seq   = $urandom;
            start = 1'b1;
            abort = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            c = 0;
            while (m_active && c < T + 4) begin
                start = ($urandom_range(0, 3) == 0);
                if (start) seq = $urandom;
                abort = ($urandom_range(0, 59) == 0);
                SDRD  = 1'($urandom);
                if ($urandom_range(0, 199) == 0) begin
                    #2 rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                end else begin
                    @(negedge clk);
                end
                c++;
            end
            start = 1'b0; abort = 1'b0;
            if (m_active) begin
                errors++;
                $display("FAIL txn_timeout actual=busy required=idle");
            end
            $display("txn %0d data=%h model=%h", t, data, m_data);
        end

        repeat (2) @(negedge clk);
        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
